lsu_byte_bus: RTL and testbench

//  Memory-side end of the controller's memory_en/store_size interface: executes loads/stores on an 8-bit req/ack bus.

---
 rtl/lsu_byte_bus.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_byte_bus.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_bus.sv
// rtl/lsu_byte_bus.sv - load/store unit executing core memory accesses as 1/2/4 byte beats on an 8-bit req/ack bus
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   memory_en                   core requests a memory access this cycle
//   store_size[1:0]             00 SB, 01 SH, 10 SW, 11 load
//   funct3[2:0]                 load kind: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   addr[31:0], wdata[31:0]     effective byte address, store data
//   stall                       core must hold PC/inputs this cycle
//   rdata[31:0], rdata_valid    extended load result, 1-cycle completion pulse
//   access_err, err_code[1:0]   1-cycle failure pulse, held cause (01 misaligned, 10 timeout, 11 illegal)
//   bus_req, bus_we             beat request, write/read
//   bus_addr, bus_wdata         beat byte address, write byte
//   bus_rdata, bus_ack          read byte, beat complete

module lsu_byte_bus #(
   parameter int BUS_ADDR_W  = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_en,
   input  logic [1:0]            store_size,
   input  logic [2:0]            funct3,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   output logic                  stall,
   output logic [31:0]           rdata,
   output logic                  rdata_valid,
   output logic                  access_err,
   output logic [1:0]            err_code,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [BUS_ADDR_W-1:0] bus_addr,
   output logic [7:0]            bus_wdata,
   input  logic [7:0]            bus_rdata,
   input  logic                  bus_ack
);

   localparam logic [7:0] TIMER_LAST   = 8'(ACK_TIMEOUT - 1);
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t      state;
   logic [1:0]  beat;
   logic [1:0]  last_beat;
   logic [7:0]  timer;
   logic [23:0] wdata_rest;   // store bytes still to be sent, next one in [7:0]
   logic [31:0] load_buf;
   logic [2:0]  kind;
   logic        is_load;

   // Request decode, only meaningful in the accept cycle.
   logic       req_load;
   logic [1:0] size_code;
   logic       req_illegal;
   logic       req_misaligned;
   logic [1:0] req_last;

   always_comb begin
      req_load       = (store_size == 2'b11);
      // Stores take their size from store_size; funct3 only matters for loads.
      size_code      = req_load ? funct3[1:0] : store_size;
      req_illegal    = req_load && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
      req_misaligned = ((size_code == 2'b01) && addr[0]) ||
                       ((size_code == 2'b10) && (addr[1:0] != 2'b00));
      case (size_code)
         2'b00:   req_last = 2'd0;
         2'b01:   req_last = 2'd1;
         default: req_last = 2'd3;
      endcase
   end

   // Load word including the byte arriving this cycle, so the final beat
   // can be extended and registered on the same edge it is acknowledged.
   logic [31:0] load_word;
   logic [31:0] load_ext;

   always_comb begin
      load_word = load_buf;
      case (beat)
         2'd0:    load_word[7:0]   = bus_rdata;
         2'd1:    load_word[15:8]  = bus_rdata;
         2'd2:    load_word[23:16] = bus_rdata;
         default: load_word[31:24] = bus_rdata;
      endcase
      case (kind)
         3'b000:  load_ext = {{24{load_word[7]}},  load_word[7:0]};
         3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
         3'b100:  load_ext = {24'h000000, load_word[7:0]};
         3'b101:  load_ext = {16'h0000,   load_word[15:0]};
         default: load_ext = load_word;
      endcase
   end

   // Combinational so the core is held in the very cycle the access is accepted.
   assign stall = !reset && (((state == ST_IDLE) && memory_en) || (state == ST_ACCESS));

   // Upper address bits beyond the bus width are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, addr};

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         beat        <= 2'd0;
         last_beat   <= 2'd0;
         timer       <= 8'd0;
         wdata_rest  <= 24'd0;
         load_buf    <= 32'd0;
         kind        <= 3'd0;
         is_load     <= 1'b0;
         rdata       <= 32'd0;
         rdata_valid <= 1'b0;
         access_err  <= 1'b0;
         err_code    <= 2'b00;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= 8'd0;
      end else begin
         rdata_valid <= 1'b0;
         access_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (memory_en) begin
                  kind       <= funct3;
                  is_load    <= req_load;
                  last_beat  <= req_last;
                  beat       <= 2'd0;
                  timer      <= 8'd0;
                  load_buf   <= 32'd0;
                  wdata_rest <= wdata[31:8];
                  if (req_illegal) begin
                     err_code   <= ERR_ILLEGAL;
                     access_err <= 1'b1;
                     state      <= ST_DONE;
                  end else if (req_misaligned) begin
                     err_code   <= ERR_MISALIGN;
                     access_err <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     bus_req   <= 1'b1;
                     bus_we    <= !req_load;
                     bus_addr  <= addr[BUS_ADDR_W-1:0];
                     bus_wdata <= wdata[7:0];
                     state     <= ST_ACCESS;
                  end
               end
            end

            ST_ACCESS: begin
               // bus_req is always high here, so bus_ack alone completes a beat.
               if (bus_ack) begin
                  if (beat == last_beat) begin
                     bus_req <= 1'b0;
                     bus_we  <= 1'b0;
                     state   <= ST_DONE;
                     if (is_load) begin
                        rdata       <= load_ext;
                        rdata_valid <= 1'b1;
                     end
                  end else begin
                     beat       <= beat + 2'd1;
                     timer      <= 8'd0;
                     bus_addr   <= bus_addr + BUS_ADDR_W'(1);
                     bus_wdata  <= wdata_rest[7:0];
                     wdata_rest <= {8'h00, wdata_rest[23:8]};
                     load_buf   <= load_word;
                  end
               end else if (timer == TIMER_LAST) begin
                  bus_req    <= 1'b0;
                  bus_we     <= 1'b0;
                  err_code   <= ERR_TIMEOUT;
                  access_err <= 1'b1;
                  load_buf   <= 32'd0;
                  state      <= ST_DONE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_bus.sv
// tb/tb_lsu_byte_bus.sv - randomized self-checking bench for lsu_byte_bus against a cycle-timeline model

module tb_lsu_byte_bus;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memory_en = 1'b0;
   logic [1:0]  store_size = 2'b00;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        access_err;
   logic [1:0]  err_code;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata = 8'd0;
   logic        bus_ack = 1'b0;

   lsu_byte_bus #(.BUS_ADDR_W(16), .ACK_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .memory_en(memory_en), .store_size(store_size),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
      .rdata_valid(rdata_valid), .access_err(access_err), .err_code(err_code),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_rdata = 32'd0;
   logic [1:0]  m_err = 2'b00;
   int          dly[4];
   logic [7:0]  rb[4];
   logic [7:0]  wmem [0:65535];
   int          o_stall;
   int          o_req;
   logic [31:0] o_rdata;
   logic        o_rv;
   logic        o_ae;
   logic [1:0]  o_ec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every observable output against what the model says this cycle must show.
   task automatic sample(input logic e_stall, input logic e_req, input logic e_rv, input logic e_ae,
                         input logic e_we, input logic [15:0] e_addr, input logic [7:0] e_wd);
      o_stall += int'(stall);
      o_req   += int'(bus_req);
      chk("stall", stall, e_stall);
      chk("bus_req", bus_req, e_req);
      if (e_req) begin
         chk("bus_we", bus_we, e_we);
         chk("bus_addr", bus_addr, e_addr);
         chk("bus_wdata", bus_wdata, e_wd);
      end
      chk("rdata_valid", rdata_valid, e_rv);
      chk("access_err", access_err, e_ae);
      chk("rdata", rdata, m_rdata);
      chk("err_code", err_code, m_err);
   endtask

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
      logic [31:0] r;
      case (f3)
         3'd0: begin r = v & 32'hFF;   if (r >= 32'h80)   r = r - 32'h100;   end
         3'd1: begin r = v & 32'hFFFF; if (r >= 32'h8000) r = r - 32'h10000; end
         3'd4: r = v & 32'hFF;
         3'd5: r = v & 32'hFFFF;
         default: r = v;
      endcase
      return r;
   endfunction

   task automatic set_beats(input int d0, input int d1, input int d2, input int d3,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
      rb[0] = b0;  rb[1] = b1;  rb[2] = b2;  rb[3] = b3;
   endtask

   task automatic idle();
      @(negedge clk);
      memory_en = 1'b0;
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = 8'($urandom);
      #1;
      sample(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
   endtask

   // One access: the bus side acks beat k after dly[k] wait cycles with byte rb[k].
   task automatic txn(input logic [1:0] ss, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic done_en);
      logic        ld;
      int          n;
      logic [1:0]  e;
      logic [31:0] val;
      logic        acked;
      ld = (ss == 2'b11);
      if (ld) n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      else    n = (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : 4;
      e = 2'b00;
      if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) e = 2'b11;
      else if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) e = 2'b01;
      o_stall = 0;
      o_req   = 0;
      val     = 32'd0;

      @(negedge clk);
      memory_en  = 1'b1;
      store_size = ss;
      funct3     = f3;
      addr       = a;
      wdata      = wd;
      bus_ack    = 1'($urandom_range(0, 1));
      bus_rdata  = 8'($urandom);
      #1;
      sample(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

      if (e == 2'b00) begin
         for (int k = 0; k < n; k++) begin
            acked = 1'b0;
            for (int w = 0; w < T; w++) begin
               @(negedge clk);
               bus_ack   = (w == dly[k]);
               bus_rdata = (w == dly[k]) ? rb[k] : 8'($urandom);
               #1;
               sample(1'b1, 1'b1, 1'b0, 1'b0, !ld, 16'(a + 32'(k)), 8'(wd >> (8 * k)));
               if (bus_ack) begin
                  acked = 1'b1;
                  if (bus_req && bus_we) wmem[bus_addr] = bus_wdata;
                  break;
               end
            end
            if (!acked) begin
               e = 2'b10;
               break;
            end
            val = val | (32'(rb[k]) << (8 * k));
         end
      end

      @(negedge clk);
      memory_en = done_en;
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = 8'($urandom);
      #1;
      if (e != 2'b00) m_err = e;
      else if (ld) m_rdata = extend(f3, val);
      o_rdata = rdata;
      o_rv    = rdata_valid;
      o_ae    = access_err;
      o_ec    = err_code;
      sample(1'b0, 1'b0, (e == 2'b00) && ld, e != 2'b00, 1'b0, 16'h0, 8'h0);
   endtask

   initial begin
      logic [1:0]  ss;
      logic [2:0]  f3;
      logic [31:0] a;
      int          legal_f3[5];
      legal_f3 = '{0, 1, 2, 4, 5};

      // Reset state, with memory_en toggling while reset is held.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         reset     = 1'b1;
         memory_en = 1'(i == 2);
         bus_ack   = 1'(i == 1);
         #1;
         sample(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      end
      chk("reset_bus_we", bus_we, 1'b0);
      chk("reset_bus_addr", bus_addr, 16'h0);
      chk("reset_bus_wdata", bus_wdata, 8'h0);
      @(negedge clk);
      reset     = 1'b0;
      memory_en = 1'b0;
      bus_ack   = 1'b0;
      #1;
      sample(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

      // SW, zero-wait acks.
      set_beats(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      txn(2'b10, 3'd7, 32'h100, 32'hA1B2C3D4, 1'b1);
      chk("sw_stall_cycles", o_stall, 5);
      chk("sw_byte0", wmem[16'h100], 8'hD4);
      chk("sw_byte1", wmem[16'h101], 8'hC3);
      chk("sw_byte2", wmem[16'h102], 8'hB2);
      chk("sw_byte3", wmem[16'h103], 8'hA1);
      chk("sw_pulses", {o_rv, o_ae}, 2'b00);

      // LB / LBU of 0x80.
      set_beats(0, 0, 0, 0, 8'h80, 8'h00, 8'h00, 8'h00);
      txn(2'b11, 3'd0, 32'h101, 32'h0, 1'b0);
      chk("lb_rdata", o_rdata, 32'hFFFFFF80);
      chk("lb_valid", o_rv, 1'b1);
      chk("lb_stall_cycles", o_stall, 2);
      txn(2'b11, 3'd4, 32'h101, 32'h0, 1'b1);
      chk("lbu_rdata", o_rdata, 32'h00000080);

      // LW with three wait cycles per beat.
      set_beats(3, 3, 3, 3, 8'h11, 8'h22, 8'h33, 8'h44);
      txn(2'b11, 3'd2, 32'h200, 32'h0, 1'b0);
      chk("lw_rdata", o_rdata, 32'h44332211);
      chk("lw_stall_cycles", o_stall, 17);

      // Misaligned LH, illegal funct3.
      txn(2'b11, 3'd1, 32'h103, 32'h0, 1'b0);
      chk("lh_misalign_req", o_req, 0);
      chk("lh_misalign_err", {o_ae, o_ec}, 3'b101);
      txn(2'b11, 3'd3, 32'h100, 32'h0, 1'b1);
      chk("illegal_req", o_req, 0);
      chk("illegal_err", {o_ae, o_ec}, 3'b111);

      // Ack never arrives.
      set_beats(1000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      txn(2'b11, 3'd0, 32'h40, 32'h0, 1'b0);
      chk("timeout_req_cycles", o_req, T);
      chk("timeout_err", {o_ae, o_ec}, 3'b110);
      chk("timeout_stall_cycles", o_stall, T + 1);

      // Reset during the second beat of a SW; late acks must be ignored.
      @(negedge clk);
      memory_en = 1'b1; store_size = 2'b10; funct3 = 3'd0;
      addr = 32'h300; wdata = 32'h55667788; bus_ack = 1'b0;
      #1;
      sample(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
      bus_ack = 1'b1;
      #1;
      sample(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h300, 8'h88);
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      sample(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h301, 8'h77);
      @(negedge clk);
      reset   = 1'b1;
      bus_ack = 1'b1;
      #1;
      sample(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h301, 8'h77);
      m_rdata = 32'd0;
      m_err   = 2'b00;
      @(negedge clk);
      memory_en = 1'b0;
      #1;
      sample(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      sample(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      repeat (3) idle();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         ss = 2'($urandom_range(0, 3));
         if (ss == 2'b11 && $urandom_range(0, 9) == 0)
            f3 = ($urandom_range(0, 2) == 0) ? 3'd3 : ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
         else if (ss == 2'b11)
            f3 = 3'(legal_f3[$urandom_range(0, 4)]);
         else
            f3 = 3'($urandom);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) a[15:2] = 14'h3FFF;
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 19))
               0:       dly[k] = T - 1;
               1:       dly[k] = T + int'($urandom_range(0, 3));
               default: dly[k] = int'($urandom_range(0, 2));
            endcase
            rb[k] = 8'($urandom);
         end
         txn(ss, f3, a, $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
